// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction fetch front end. Generates sequential fetch addresses,
//   issues them to instruction memory, buffers the returned instructions
//   in a 2-entry FIFO and hands them to decode with a valid/ready handshake.
//   A branch redirect reloads the PC, drops everything buffered or in
//   flight and spends one FLUSH cycle before fetching resumes.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   FIFO_DEPTH   instruction buffer entries (only 2 is supported)
//
// Ports
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   Stall                blocks new fetch issue while high
//   BranchTaken          one-cycle redirect request
//   BranchTarget[31:0]   redirect byte address
//   PC[31:0]             fetch address to instruction memory
//   MemRead              fetch issue strobe
//   Instruction[31:0]    memory data, valid the cycle after an issue
//   IF_Instr/IF_PC       FIFO head toward decode
//   IF_Valid             FIFO non-empty
//   IF_Ready             decode accepts the head this cycle
//   MisalignErr          (FETCH_MISALIGN_TRAP_EN only) sticky misaligned
//                        redirect flag; fetch stays halted until reset
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a target with
//   BranchTarget[1:0]!=0 traps instead of loading the PC. When undefined,
//   the low two target bits are simply forced to zero.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PC,
    output logic        MemRead,
    input  logic [31:0] Instruction,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PC,
    output logic        IF_Valid,
    input  logic        IF_Ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        MisalignErr
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] LP_DEPTH = 2'(FIFO_DEPTH);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ipc;          // address of the fetch currently in memory
    logic        r_inflight;
    logic [31:0] r_mem_instr [0:1];
    logic [31:0] r_mem_pc    [0:1];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_redirect;
    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_occ;
    logic        w_trap;
    logic        w_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_misalign;
    assign w_trap      = r_misalign;
    assign w_bad       = (BranchTarget[1:0] != 2'b00);
    assign MisalignErr = r_misalign;
`else
    assign w_trap      = 1'b0;
    assign w_bad       = 1'b0;
`endif

    // Occupancy counts the inflight fetch as a reserved slot, so the
    // response that lands next cycle can never find the FIFO full.
    assign w_occ      = r_count + {1'b0, r_inflight};
    assign w_redirect = BranchTaken && (r_state != S_IDLE);

    // MemRead is decoded from registered state plus this cycle's Stall and
    // BranchTaken so that a redirect suppresses the issue in the same cycle.
    assign w_issue    = (r_state == S_RUN) && !Stall && !BranchTaken &&
                        !w_trap && (w_occ < LP_DEPTH);
    assign w_push     = r_inflight;
    assign w_pop      = IF_Valid && IF_Ready;

    assign MemRead    = w_issue;
    assign PC         = r_pc;
    assign IF_Valid   = (r_count != 2'd0);
    assign IF_Instr   = r_mem_instr[r_rd_ptr];
    assign IF_PC      = r_mem_pc[r_rd_ptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ipc      <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE:         r_state <= S_RUN;
                S_RUN, S_FLUSH: r_state <= w_redirect ? S_FLUSH : S_RUN;
                default:        r_state <= S_IDLE;
            endcase

            if (w_redirect) begin
                // Redirect wins over everything: the buffered entries and the
                // response arriving this cycle are both dropped.
                r_count    <= '0;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
                r_inflight <= 1'b0;
                if (!w_bad && !w_trap)
                    r_pc <= BranchTarget & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (w_bad)
                    r_misalign <= 1'b1;
`endif
            end else begin
                if (w_issue) begin
                    r_ipc <= r_pc;
                    r_pc  <= r_pc + 32'd4;
                end
                // Any inflight response is pushed this cycle, so inflight
                // only survives if a new fetch goes out now.
                r_inflight <= w_issue;
                if (w_push) begin
                    r_mem_instr[r_wr_ptr] <= Instruction;
                    r_mem_pc[r_wr_ptr]    <= r_ipc;
                    r_wr_ptr              <= ~r_wr_ptr;
                end
                if (w_pop)
                    r_rd_ptr <= ~r_rd_ptr;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Drives pc_fetch_unit with directed scenarios and a randomized run and
//   compares every cycle against a queue-based model of the fetch rules.
//   Instruction memory is modelled as a hash of the issued address.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] Instruction = '0;
    logic        IF_Ready = 1'b0;
    logic [31:0] PC;
    logic        MemRead;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC;
    logic        IF_Valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        MisalignErr;
`endif

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .PC(PC), .MemRead(MemRead),
        .Instruction(Instruction), .IF_Instr(IF_Instr), .IF_PC(IF_PC),
        .IF_Valid(IF_Valid), .IF_Ready(IF_Ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .MisalignErr(MisalignErr)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // model: phase 0 = idle, 1 = run, 2 = flush
    int          m_phase;
    bit          m_trap;
    bit          m_infl;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [63:0] m_q[$];          // {instr, pc}, head at index 0

    // observations of the last stepped cycle, for directed literal checks
    logic        o_mr, o_v;
    logic [31:0] o_pc, o_ifpc;
    logic        last_v;
    logic [31:0] last_a;
    logic [31:0] issued[$];

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_PC", PC, 32'h0);
        chk("rst_MemRead", {31'b0, MemRead}, 32'h0);
        chk("rst_IF_Valid", {31'b0, IF_Valid}, 32'h0);
        chk("rst_IF_Instr", IF_Instr, 32'h0);
        chk("rst_IF_PC", IF_PC, 32'h0);
        m_phase = 0; m_trap = 0; m_infl = 0; m_pc = 32'h0; m_ipc = 32'h0;
        m_q.delete();
        last_v = 1'b0;
        Stall = 1'b0; BranchTaken = 1'b0; IF_Ready = 1'b0;
        @(posedge CLK);
        #2 RST_N = 1'b1;
    endtask

    // One clock cycle: drive, compare against the model, then advance it.
    task automatic step(input bit s, input bit bt, input logic [31:0] tgt, input bit rdy);
        bit exp_mr;
        @(negedge CLK);
        Stall = s; BranchTaken = bt; BranchTarget = tgt; IF_Ready = rdy;
        Instruction = last_v ? imem(last_a) : $urandom;
        #1;
        exp_mr = (m_phase == 1) && !s && !bt && !m_trap && (m_q.size() + int'(m_infl) < 2);
        chk("MemRead", {31'b0, MemRead}, {31'b0, exp_mr});
        chk("PC", PC, m_pc);
        chk("IF_Valid", {31'b0, IF_Valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("IF_PC", IF_PC, m_q[0][31:0]);
            chk("IF_Instr", IF_Instr, m_q[0][63:32]);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("MisalignErr", {31'b0, MisalignErr}, {31'b0, m_trap});
`endif
        o_mr = MemRead; o_v = IF_Valid; o_pc = PC; o_ifpc = IF_PC;
        last_v = MemRead; last_a = PC;
        if (MemRead) issued.push_back(PC);
        @(posedge CLK);
        if (bt && m_phase != 0) begin
            m_q.delete();
            m_infl = 0;
            if (TRAP && tgt[1:0] != 2'b00) m_trap = 1;
            else if (!m_trap) m_pc = tgt & ~32'h3;
            m_phase = 2;
        end else begin
            if (rdy && m_q.size() > 0) void'(m_q.pop_front());
            if (m_infl) m_q.push_back({Instruction, m_ipc});
            if (exp_mr) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
                m_infl = 1;
            end else begin
                m_infl = 0;
            end
            m_phase = 1;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        bit s, bt, rdy;

        // free run from reset
        do_reset();
        step(0, 0, 0, 1);
        chk("run_idle_mr", {31'b0, o_mr}, 32'h0);
        step(0, 0, 0, 1);
        chk("run_first_mr", {31'b0, o_mr}, 32'h1);
        chk("run_first_pc", o_pc, 32'h0);
        step(0, 0, 0, 1);
        chk("run_second_pc", o_pc, 32'h4);
        step(0, 0, 0, 1);
        chk("run_first_valid", {31'b0, o_v}, 32'h1);
        chk("run_first_ifpc", o_ifpc, 32'h0);
        repeat (10) step(0, 0, 0, 1);

        // decode backpressure fills the buffer, then drains in order
        do_reset();
        repeat (8) step(0, 0, 0, 0);
        chk("bp_valid", {31'b0, o_v}, 32'h1);
        chk("bp_ifpc", o_ifpc, 32'h0);
        chk("bp_mr", {31'b0, o_mr}, 32'h0);
        step(0, 0, 0, 1);
        chk("bp_pop0", o_ifpc, 32'h0);
        step(0, 0, 0, 1);
        chk("bp_pop1", o_ifpc, 32'h4);
        step(0, 0, 0, 1);
        chk("bp_empty", {31'b0, o_v}, 32'h0);

        // redirect while a fetch is inflight
        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 32'h40, 1);
        chk("br_mr", {31'b0, o_mr}, 32'h0);
        step(0, 0, 0, 1);
        chk("br_flush_mr", {31'b0, o_mr}, 32'h0);
        chk("br_flush_v", {31'b0, o_v}, 32'h0);
        step(0, 0, 0, 1);
        chk("br_next_mr", {31'b0, o_mr}, 32'h1);
        chk("br_next_pc", o_pc, 32'h40);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("br_head", o_ifpc, 32'h40);

        // redirect together with stall
        do_reset();
        repeat (3) step(0, 0, 0, 1);
        step(1, 1, 32'h100, 1);
        chk("bs_mr", {31'b0, o_mr}, 32'h0);
        repeat (3) begin
            step(1, 0, 0, 1);
            chk("bs_hold_mr", {31'b0, o_mr}, 32'h0);
            chk("bs_hold_pc", o_pc, 32'h100);
        end
        step(0, 0, 0, 1);
        chk("bs_resume_mr", {31'b0, o_mr}, 32'h1);
        chk("bs_resume_pc", o_pc, 32'h100);

        // PC wrap-around
        do_reset();
        step(0, 0, 0, 1);
        step(0, 1, 32'hFFFF_FFF8, 1);
        issued.delete();
        repeat (8) step(0, 0, 0, 1);
        chk("wrap_count_ok", {31'b0, issued.size() >= 3}, 32'h1);
        if (issued.size() >= 3) begin
            chk("wrap_0", issued[0], 32'hFFFF_FFF8);
            chk("wrap_1", issued[1], 32'hFFFF_FFFC);
            chk("wrap_2", issued[2], 32'h0000_0000);
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // misaligned redirect traps until reset
        do_reset();
        repeat (3) step(0, 0, 0, 1);
        step(0, 1, 32'h42, 1);
        repeat (6) begin
            step(0, 0, 0, 1);
            chk("trap_mr", {31'b0, o_mr}, 32'h0);
            chk("trap_v", {31'b0, o_v}, 32'h0);
            chk("trap_err", {31'b0, MisalignErr}, 32'h1);
        end
`else
        // misaligned target has its low bits dropped
        do_reset();
        repeat (2) step(0, 0, 0, 1);
        step(0, 1, 32'h42, 1);
        step(0, 0, 0, 1);
        chk("mis_pc", o_pc, 32'h40);
`endif

        // randomized run with occasional mid-operation resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            s   = ($urandom_range(0, 3) == 0);
            bt  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) tgt[31:4] = 28'hFFF_FFFF;
            if (TRAP || $urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
            step(s, bt, tgt, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the instruction buffer entries (fixed at 2; other values unsupported).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Stall, input, 1, which suppresses new fetch issue while high.
REQ-006 SHALL have port BranchTaken, input, 1, a one-cycle redirect request.
REQ-007 SHALL have port BranchTarget, input, 32, the redirect byte address.
REQ-008 SHALL have port PC, output, 32, the byte address driven to instruction memory.
REQ-009 SHALL have port MemRead, output, 1, the fetch issue strobe to instruction memory.
REQ-010 SHALL have port Instruction, input, 32, the instruction-memory data, valid the cycle after a MemRead issue.
REQ-011 SHALL have port IF_Instr, output, 32, the buffered instruction toward decode.
REQ-012 SHALL have port IF_PC, output, 32, the byte address of IF_Instr.
REQ-013 SHALL have port IF_Valid, output, 1, which is high when the buffer is non-empty.
REQ-014 SHALL have port IF_Ready, input, 1, the decode accept signal; a pop occurs on IF_Valid and IF_Ready both high.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-016 SHALL enter IDLE on reset, move to RUN on the next edge, and hold MemRead=0 while in IDLE.
REQ-017 SHALL, in RUN, assert MemRead when Stall=0, BranchTaken=0 and (count + inflight) < 2.
REQ-018 SHALL, on each issue, capture PC into an inflight-PC register, set the inflight flag, and advance PC by 4 with wrap-around modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-019 SHALL, with inflight set, push {Instruction, inflight-PC} into the FIFO one cycle after issue, then clear inflight unless a new issue occurs that same cycle.
REQ-020 SHALL allow a push and a pop in the same cycle, leaving count unchanged and preserving FIFO order.
REQ-021 SHALL keep the issue rule such that a push never targets a full FIFO; no overflow path shall exist.
REQ-022 SHALL drive IF_Instr and IF_PC from the FIFO head and hold them stable while IF_Valid=1 and IF_Ready=0.
REQ-023 SHALL, on BranchTaken=1 in any state other than IDLE, do all of the following: load PC with BranchTarget, clear the FIFO, clear inflight and discard that cycle's Instruction, deassert MemRead, and go to FLUSH.
REQ-024 SHALL give BranchTaken priority over Stall, pop and push in the same cycle.
REQ-025 SHALL spend exactly one cycle in FLUSH with MemRead=0, then return to RUN; BranchTaken during FLUSH re-applies REQ-023.
REQ-026 SHALL let Stall block only new issues; an inflight response is still pushed and pops still occur.
REQ-027 SHALL give a fetch-to-IF_Valid latency of 2 cycles from MemRead into an empty FIFO.

Reset
REQ-028 SHALL, on RST_N=0, immediately force PC=RESET_PC, MemRead=0, IF_Valid=0, IF_Instr=0, IF_PC=0, count=0, inflight=0, state=IDLE.
REQ-029 SHALL, on reset mid-operation, discard all buffered and inflight instructions, with no output glitch beyond the forced values.
REQ-030 SHALL release reset without hazard, with first issue no earlier than the second rising edge after deassertion.

Configuration
REQ-031 SHALL, when FETCH_MISALIGN_TRAP_EN is defined, add output MisalignErr (1 bit): a redirect with BranchTarget[1:0]!=0 sets MisalignErr=1 sticky, loads no PC, clears the FIFO, and holds MemRead=0 until reset.
REQ-032 SHALL, when FETCH_MISALIGN_TRAP_EN is not defined, have no MisalignErr port, and BranchTarget[1:0] shall be forced to 0 on load.

Verification
REQ-033 SHALL cover reset then free run with IF_Ready=1 and Stall=0 -> MemRead first high in cycle 2, PC sequence 0,4,8,..., first IF_Valid with IF_PC=0 two cycles later.
REQ-034 SHALL cover IF_Ready=0 held -> exactly 2 entries buffered, MemRead low, IF_PC=0 stable; then IF_Ready=1 -> pops in order 0,4 with no loss or duplication.
REQ-035 SHALL cover BranchTaken with BranchTarget=32'h40 while an issue is inflight -> FIFO emptied, inflight data never appears, one FLUSH bubble, next MemRead with PC=32'h40.
REQ-036 SHALL cover BranchTaken and Stall high in the same cycle -> redirect taken, PC=BranchTarget, then no issue until Stall=0.
REQ-037 SHALL cover PC reaching 32'hFFFFFFFC -> next issued PC=32'h00000000.
REQ-038 SHALL cover, with FETCH_MISALIGN_TRAP_EN defined, BranchTarget=32'h42 -> MisalignErr=1, IF_Valid=0 and MemRead=0 held until RST_N=0.
